// File: rtl/pipe_pkg.sv
// Shared constants for the RV32I hazard/forwarding logic.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pipe_pkg;

  // Operand-forward select encodings driven to the EX operand muxes
  localparam logic [1:0] FWD_RF  = 2'b00;  // value read from the register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // result being written back this cycle
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result sitting in the MEM stage

  // x0 is hard-wired to zero and must never be treated as a producer
  localparam int REG_X0 = 0;

  // Load-use stall controller states
  typedef enum logic {
    IDLE   = 1'b0,
    LSTALL = 1'b1
  } hzState_t;

endpackage

// File: rtl/fwd_select.sv
// Operand-forward comparator for one EX source operand.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the select is valid whenever its inputs are.
//
// Ports:
//   rsnE      - EX-stage source register number
//   rdnM      - destination tag of the instruction in MEM
//   RegWriteM - MEM instruction writes its rd
//   rdnW      - destination tag of the instruction in WB
//   RegWriteW - WB instruction writes its rd
//   fwdSel    - operand mux select (FWD_RF / FWD_WB / FWD_MEM)
module fwd_select
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rsnE,
  input  logic [REG_ADDR_W-1:0] rdnM,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] rdnW,
  input  logic                  RegWriteW,
  output logic [1:0]            fwdSel
);

  logic hitM;
  logic hitW;

  // A writer of x0 produces nothing architecturally visible, so it never matches
  assign hitM = RegWriteM && (rdnM != REG_ADDR_W'(REG_X0)) && (rdnM == rsnE);
  assign hitW = RegWriteW && (rdnW != REG_ADDR_W'(REG_X0)) && (rdnW == rsnE);

  // MEM holds the younger producer, so it wins over WB
  always_comb begin
    fwdSel = FWD_RF;
    if (hitM) begin
      fwdSel = FWD_MEM;
    end else if (hitW) begin
      fwdSel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding control for the 5-stage RV32I pipeline.
// Latency: forward selects and stall/flush are combinational; shadow tags and stall FSM update each clk.
// Backpressure: raises StallF/StallD (+FlushE bubble) on load-use; a taken branch overrides any stall.
//
// Ports:
//   clk, rst               - pipeline clock, synchronous active-high reset
//   rs1nD, rs2nD           - decode-stage source register numbers
//   rs1nE, rs2nE, rdnE     - execute-stage register numbers from ID/EX
//   RegWriteE, ResultSrcE  - EX instruction writes rd / is a load
//   PCSrcE                 - branch or jump taken, resolved in EX
//   ForwardAE, ForwardBE   - EX operand mux selects
//   StallF, StallD         - hold PC / hold IF/ID
//   FlushD, FlushE         - clear IF/ID / clear ID/EX
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,  // legal range 1..7 (3-bit countdown)
  parameter int REG_ADDR_W        = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1nD,
  input  logic [REG_ADDR_W-1:0] rs2nD,
  input  logic [REG_ADDR_W-1:0] rs1nE,
  input  logic [REG_ADDR_W-1:0] rs2nE,
  input  logic [REG_ADDR_W-1:0] rdnE,
  input  logic                  RegWriteE,
  input  logic                  ResultSrcE,
  input  logic                  PCSrcE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE
);

  localparam logic [2:0] CNT_LOAD = 3'(LOAD_STALL_CYCLES - 1);

  // Shadow copy of the MEM/WB destination tags
  logic [REG_ADDR_W-1:0] rdnM;
  logic [REG_ADDR_W-1:0] rdnW;
  logic                  RegWriteM;
  logic                  RegWriteW;

  // The EX instruction always advances (stalls only hold IF/ID), so the
  // shadow pipeline is never gated.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdnM      <= '0;
      rdnW      <= '0;
      RegWriteM <= 1'b0;
      RegWriteW <= 1'b0;
    end else begin
      rdnM      <= rdnE;
      RegWriteM <= RegWriteE;
      rdnW      <= rdnM;
      RegWriteW <= RegWriteM;
    end
  end

  // Forwarding
  logic [1:0] fwdA;
  logic [1:0] fwdB;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) uFwdA (
    .rsnE      (rs1nE),
    .rdnM      (rdnM),
    .RegWriteM (RegWriteM),
    .rdnW      (rdnW),
    .RegWriteW (RegWriteW),
    .fwdSel    (fwdA)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) uFwdB (
    .rsnE      (rs2nE),
    .rdnM      (rdnM),
    .RegWriteM (RegWriteM),
    .rdnW      (rdnW),
    .RegWriteW (RegWriteW),
    .fwdSel    (fwdB)
  );

  // Load-use detection: a load in EX whose rd is read by the decode instruction
  logic loadUse;
  assign loadUse = RegWriteE && ResultSrcE && (rdnE != REG_ADDR_W'(REG_X0)) &&
                   ((rdnE == rs1nD) || (rdnE == rs2nD));

  // Stall FSM. The first stall cycle is raised combinationally from IDLE;
  // LSTALL covers the remaining LOAD_STALL_CYCLES-1 cycles.
  hzState_t   state;
  hzState_t   stateNext;
  logic [2:0] cnt;
  logic [2:0] cntNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (PCSrcE) begin
      // The instructions behind the taken branch are squashed, so the load
      // consumer no longer exists: abandon any stall in progress.
      stateNext = IDLE;
      cntNext   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (loadUse && (LOAD_STALL_CYCLES > 1)) begin
            stateNext = LSTALL;
            cntNext   = CNT_LOAD;
          end
        end
        LSTALL: begin
          if (cnt == 3'd1) begin
            stateNext = IDLE;
            cntNext   = 3'd0;
          end else begin
            cntNext = cnt - 3'd1;
          end
        end
        default: begin
          stateNext = IDLE;
          cntNext   = 3'd0;
        end
      endcase
    end
  end

  // Output stage: reset masks everything, a taken branch masks the stall
  logic stallRaw;
  assign stallRaw = (loadUse && (state == IDLE)) || (state == LSTALL);

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    if (!rst) begin
      ForwardAE = fwdA;
      ForwardBE = fwdB;
      StallF    = stallRaw && !PCSrcE;
      StallD    = stallRaw && !PCSrcE;
      FlushD    = PCSrcE;
      // A stalled decode instruction must not also enter EX: bubble it
      FlushE    = (stallRaw && !PCSrcE) || PCSrcE;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard and forwarding control for the 5-stage RV32I pipeline.
- Consumes the execute-side outputs of the ID/EX pipeline register (source/destination register numbers, RegWrite, ResultSrc) and the decode-stage source numbers.
- Keeps its own shadow copy of the MEM and WB destination tags.
- Drives operand-forward selects to the EX muxes, and stall/flush controls back to the IF/ID and ID/EX registers.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted on a load-use hazard (1..7); >1 models a slower data memory.
- REG_ADDR_W, 5, register-number width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- rs1nD  in  REG_ADDR_W  decode-stage rs1 number
- rs2nD  in  REG_ADDR_W  decode-stage rs2 number
- rs1nE  in  REG_ADDR_W  execute-stage rs1 number (from ID/EX)
- rs2nE  in  REG_ADDR_W  execute-stage rs2 number
- rdnE  in  REG_ADDR_W  execute-stage rd number
- RegWriteE  in  1  execute instruction writes rd
- ResultSrcE  in  1  1 = execute instruction is a load
- PCSrcE  in  1  branch/jump taken, resolved in EX
- ForwardAE  out  2  ALU operand A select: 00 = register file, 01 = WB result, 10 = MEM ALU result
- ForwardBE  out  2  ALU operand B select, same encoding
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID
- FlushD  out  1  clear IF/ID
- FlushE  out  1  clear ID/EX (drives its rst-style bubble insert)

Behaviour:
- Shadow pipeline, updated every clk:
  - rdnM <= rdnE; RegWriteM <= RegWriteE; rdnW <= rdnM; RegWriteW <= RegWriteM.
  - It is never gated by stall, because the EX instruction always advances.
- Forwarding is combinational from the registered shadow state and the E inputs:
  - ForwardAE = 10 if RegWriteM and rdnM != 0 and rdnM == rs1nE.
  - Otherwise 01 if RegWriteW and rdnW != 0 and rdnW == rs1nE.
  - Otherwise 00.
  - ForwardBE is identical, using rs2nE.
  - MEM has priority over WB.
  - x0 never forwards.
- Load-use trigger: RegWriteE & ResultSrcE & rdnE != 0 & (rdnE == rs1nD | rdnE == rs2nD).
- FSM states IDLE and LSTALL, with a 3-bit countdown cnt.
  - IDLE: on trigger, if LOAD_STALL_CYCLES > 1 go to LSTALL with cnt = LOAD_STALL_CYCLES-1; otherwise stay in IDLE.
  - LSTALL: cnt decrements each clk; return to IDLE when cnt == 1 at a clk edge.
- StallF = StallD = (trigger & IDLE) | LSTALL.
- FlushE = StallD | PCSrcE.
- FlushD = PCSrcE.
- Branch taken while stalling: PCSrcE has priority.
  - StallF and StallD are forced to 0 that cycle.
  - FlushD and FlushE are asserted.
  - The FSM returns to IDLE next clk and cnt clears.
- Branch and trigger in the same IDLE cycle: the flush wins, no stall, FSM stays IDLE.
- Reset:
  - Shadow registers clear to 0; FSM goes to IDLE; cnt = 0.
  - While rst is high, all outputs are forced to 0 (forwards 00, no stall, no flush).
  - Reset mid-LSTALL aborts the stall on the next edge.
- Latency:
  - Forward selects and stall/flush are zero-cycle, combinational from the current inputs and state.
  - The state has a one-cycle update.

Decomposition:
- Shared package pipe_pkg holds the following constants:
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - REG_X0 = 0.
  - FSM state encodings IDLE and LSTALL.
- One natural sub-module, fwd_select: the combinational comparator instantiated twice, once for A and once for B.

Test Plan:
- add x5,x1,x2 then add x6,x5,x3 back-to-back: the second instruction in EX gives ForwardAE = 10 and ForwardBE = 00; no stall.
- add x5 then a nop then sub x7,x4,x5: ForwardBE = 01 when sub is in EX.
- Both MEM and WB write x5 and rs1nE = 5: ForwardAE = 10 (MEM priority). Instruction writing x0, then a user of x0: ForwardAE = 00.
- lw x8 in EX with rs2nD = 8:
  - StallF = StallD = FlushE = 1 for exactly 1 cycle.
  - The next cycle has no stall, and ForwardBE = 01 when the user reaches EX.
  - With LOAD_STALL_CYCLES = 3: stall lasts 3 consecutive cycles.
- PCSrcE = 1 during the second cycle of a 3-cycle load stall: FlushD = FlushE = 1 and StallF = 0 that cycle; FSM is IDLE next cycle.
- rst asserted mid-stall: all outputs are 0 while rst = 1; after release, no residual stall, and the shadow tags are 0 so no spurious forwarding.
